// File: rtl/motor_drive_pwm.sv
// motor_drive_pwm: dual H-bridge PWM driver with shared 2048-clock period,
// sign/magnitude speed commands, per-side direction-change dead time and
// a global enable that kills all bridge drives within one clock.
module motor_drive_pwm (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               en,
  output logic               lft_fwd,
  output logic               lft_rev,
  output logic               rght_fwd,
  output logic               rght_rev,
  output logic               prd_done
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DEAD = 1'b1
  } side_state_t;

  localparam int NSIDE = 2;

  // Side index 0 is the left wheel, index 1 the right wheel.
  logic [10:0]        cnt_r;
  logic               prd_done_r;
  logic               boundary_s;
  logic signed [11:0] spd_s      [NSIDE];
  logic [10:0]        new_duty_s [NSIDE];
  logic               new_dir_s  [NSIDE];
  side_state_t        state_r    [NSIDE];
  logic [10:0]        duty_r     [NSIDE];
  logic               dir_r      [NSIDE];
  logic               pend_dir_r [NSIDE];
  logic [5:0]         dead_cnt_r [NSIDE];
  logic               fwd_r      [NSIDE];
  logic               rev_r      [NSIDE];

  // Magnitude of a signed speed command; -2048 has no positive 12-bit
  // twin, so it saturates to the largest representable duty.
  function automatic logic [10:0] spd_mag(input logic signed [11:0] spd);
    logic [11:0] neg_v;
    neg_v = 12'd0 - spd;
    if (!spd[11]) begin
      spd_mag = spd[10:0];
    end else if (spd == 12'sh800) begin
      spd_mag = 11'h7FF;
    end else begin
      spd_mag = neg_v[10:0];
    end
  endfunction

  assign boundary_s = (cnt_r == 11'h7FF);
  assign spd_s[0]   = lft_spd;
  assign spd_s[1]   = rght_spd;

  // Decode each speed command into the duty and direction a boundary would latch.
  always_comb begin
    for (int i = 0; i < NSIDE; i++) begin
      new_dir_s[i]  = spd_s[i][11];
      new_duty_s[i] = en ? spd_mag(spd_s[i]) : 11'd0;
    end
  end

  // Free-running period counter and the registered period-boundary pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 11'd0;
      prd_done_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_r + 11'd1;
      prd_done_r <= boundary_s;
    end
  end

  // Per-side RUN/DEAD state machine with registered, mutually exclusive bridge drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSIDE; i++) begin
        state_r[i]    <= RUN;
        duty_r[i]     <= 11'd0;
        dir_r[i]      <= 1'b0;
        pend_dir_r[i] <= 1'b0;
        dead_cnt_r[i] <= 6'd0;
        fwd_r[i]      <= 1'b0;
        rev_r[i]      <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NSIDE; i++) begin
        // One "active" decision steered by a single direction bit means
        // fwd and rev can never be asserted together.
        if ((state_r[i] == RUN) && en && (cnt_r < duty_r[i])) begin
          fwd_r[i] <= ~dir_r[i];
          rev_r[i] <= dir_r[i];
        end else begin
          fwd_r[i] <= 1'b0;
          rev_r[i] <= 1'b0;
        end

        // Duty only changes at a boundary; dropping en clears it so that
        // re-enabling mid-period cannot restart pulses before a boundary.
        if (boundary_s) begin
          duty_r[i] <= new_duty_s[i];
        end else if (!en) begin
          duty_r[i] <= 11'd0;
        end else begin
          duty_r[i] <= duty_r[i];
        end

        case (state_r[i])
          RUN: begin
            if (boundary_s && (new_duty_s[i] != 11'd0) && (new_dir_s[i] != dir_r[i])) begin
              // Reversal: hold both switches off for 64 clocks (cnt 0..63).
              state_r[i]    <= DEAD;
              dead_cnt_r[i] <= 6'd63;
              pend_dir_r[i] <= new_dir_s[i];
            end else begin
              state_r[i] <= RUN;
            end
          end
          DEAD: begin
            if (dead_cnt_r[i] == 6'd0) begin
              state_r[i] <= RUN;
              dir_r[i]   <= pend_dir_r[i];
            end else begin
              dead_cnt_r[i] <= dead_cnt_r[i] - 6'd1;
            end
          end
          default: begin
            state_r[i]    <= RUN;
            dead_cnt_r[i] <= 6'd0;
          end
        endcase
      end
    end
  end

  assign lft_fwd  = fwd_r[0];
  assign lft_rev  = rev_r[0];
  assign rght_fwd = fwd_r[1];
  assign rght_rev = rev_r[1];
  assign prd_done = prd_done_r;

endmodule
